im_loader: RTL and testbench
============================

// Module: im_loader
// PURPOSE
//  Hardware program loader for the mips core's instruction memory. It takes a byte
//  stream on a valid/ready link, assembles big-endian 32-bit words and writes them
//  into U_IM starting at word address 0. It holds the core in reset (cpu_rst) until
//  the whole image is written, replacing $readmemh for on-board runs.
// PARAMETERS
//  ADDR_W   10   IM word-address width; depth = 2**ADDR_W words
// PORTS
//  clk        in   1       system clock, rising edge
//  rst        in   1       asynchronous reset, active-high
//  load_req   in   1       one-cycle pulse: abort any load and start a new image
//  rx_valid   in   1       byte available on rx_data
//  rx_data    in   8       stream byte
//  rx_ready   out  1       loader accepts byte this cycle (transfer = rx_valid & rx_ready)
//  im_we      out  1       IM write strobe, one cycle per word
//  im_addr    out  ADDR_W  IM word address
//  im_wdata   out  32      IM write data
//  cpu_rst    out  1       reset to mips core, high while loading
//  done       out  1       image fully written, core released
//  err        out  1       sticky: image longer than IM depth
// BEHAVIOUR
//  Stream format: LEN_HI, LEN_LO (16-bit word count N, MSB first), then 4*N bytes, each
//  word MSB first (same order as the hex words in code.txt).
//  Reset: state LEN_HI; cpu_rst=1; done=0; err=0; im_we=0; im_addr=0; im_wdata=0.
//  States: LEN_HI -> LEN_LO on transfer (latch N[15:8]); LEN_LO on transfer latch N[7:0],
//   then go to DONE if N==0, else to DATA; DATA -> DONE on transfer of the last byte of
//   word N-1; DONE stays in DONE until load_req.
//  rx_ready = (state != DONE) & ~load_req (combinational). No backpressure inside a load.
//  DATA: 2-bit byte counter plus 24-bit shift register. On the transfer of the 4th byte,
//   register im_we=1, im_addr=word_cnt[ADDR_W-1:0], im_wdata={shift[23:0],rx_data}, and
//   increment word_cnt (16 bit). im_we is low in every other cycle. Throughput is 1 byte/cycle.
//  Overflow: a word with word_cnt >= 2**ADDR_W is consumed but not written (im_we stays 0),
//   and err is set. err stays 1 until load_req or rst.
//  cpu_rst: 1 in LEN_HI, LEN_LO and DATA. It falls one cycle after the state enters DONE,
//   so the final IM write commits before the core's first active edge.
//   done rises in the same cycle that cpu_rst falls.
//  load_req, any state: next state LEN_HI, cpu_rst=1, done=0, err=0, word_cnt=0, byte
//   counter=0; a partial word is discarded. A load_req that coincides with rx_valid does
//   not transfer the byte (rx_ready=0).
//  rst mid-load: everything returns to reset values, and IM contents already written are
//   kept. IM words beyond N keep their previous contents.
// TESTING
//  1. After rst, stream 00 02 | 20 08 00 05 | AC 08 00 00 -> im_we pulses twice:
//     addr0=0x20080005, addr1=0xAC080000; cpu_rst falls 1 cycle after DONE; done=1.
//  2. Stream 00 00 -> no im_we; done=1 and cpu_rst=0 within 2 cycles of the LEN_LO transfer.
//  3. ADDR_W=2, N=5 -> addresses 0..3 written, 5th word consumed without write; err=1, done=1.
//  4. rx_valid toggled randomly over a 3-word image -> same IM contents as gap-free stream;
//     no transfer counted while rx_valid=0.
//  5. load_req after 2 bytes of word 1, then a fresh 1-word image 12345678 -> addr0=0x12345678
//     only; partial bytes dropped; err cleared.
//  6. rst asserted in DATA, mid-word -> all outputs return to reset values asynchronously;
//     rx_ready=1 and the loader expects LEN_HI after release.

Source files
------------

// File: rtl/im_loader.sv
`default_nettype none
// ============================================================================
// Module   : im_loader
// Brief    : Streams a length-prefixed big-endian word image into instruction
//            memory and holds the core in reset until the image is written.
// Revision : 1.0 - initial release
// ============================================================================
module im_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_LEN_HI = 2'd0,
        S_LEN_LO = 2'd1,
        S_DATA   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [16:0] c_depth = 17'(1) << ADDR_W;

    state_t             r_state;
    state_t             w_next;
    logic [15:0]        r_len;
    logic [1:0]         r_byte_cnt;
    logic [23:0]        r_shift;
    logic [15:0]        r_word_cnt;
    logic               r_im_we;
    logic [ADDR_W-1:0]  r_im_addr;
    logic [31:0]        r_im_wdata;
    logic               r_cpu_rst;
    logic               r_done;
    logic               r_err;

    logic               w_xfer;
    logic               w_word_end;
    logic               w_last_word;
    logic               w_overflow;
    logic [15:0]        w_len;

    assign rx_ready    = (r_state != S_DONE) & ~load_req;
    assign w_xfer      = rx_valid & rx_ready;
    assign w_word_end  = w_xfer & (r_state == S_DATA) & (r_byte_cnt == 2'd3);
    assign w_last_word = (r_word_cnt + 16'd1) == r_len;
    assign w_overflow  = {1'b0, r_word_cnt} >= c_depth;
    assign w_len       = {r_len[15:8], rx_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_LEN_HI;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (load_req) begin
            w_next = S_LEN_HI;
        end else begin
            case (r_state)
                S_LEN_HI: if (w_xfer) w_next = S_LEN_LO;
                S_LEN_LO: if (w_xfer) w_next = (w_len == 16'd0) ? S_DONE : S_DATA;
                S_DATA:   if (w_word_end && w_last_word) w_next = S_DONE;
                default:  w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len      <= '0;
            r_byte_cnt <= '0;
            r_shift    <= '0;
            r_word_cnt <= '0;
            r_im_we    <= 1'b0;
            r_im_addr  <= '0;
            r_im_wdata <= '0;
            r_cpu_rst  <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_im_we <= 1'b0;
            if (load_req) begin
                r_byte_cnt <= '0;
                r_word_cnt <= '0;
                r_err      <= 1'b0;
                r_cpu_rst  <= 1'b1;
                r_done     <= 1'b0;
            end else begin
                // Release trails DONE by one cycle so the last IM write lands first.
                r_cpu_rst <= (r_state != S_DONE);
                r_done    <= (r_state == S_DONE);
                if (w_xfer) begin
                    case (r_state)
                        S_LEN_HI: r_len[15:8] <= rx_data;
                        S_LEN_LO: r_len[7:0]  <= rx_data;
                        S_DATA: begin
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                            r_shift    <= {r_shift[15:0], rx_data};
                            if (r_byte_cnt == 2'd3) begin
                                r_word_cnt <= r_word_cnt + 16'd1;
                                if (w_overflow) begin
                                    r_err <= 1'b1;
                                end else begin
                                    r_im_we    <= 1'b1;
                                    r_im_addr  <= r_word_cnt[ADDR_W-1:0];
                                    r_im_wdata <= {r_shift, rx_data};
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign im_we    = r_im_we;
    assign im_addr  = r_im_addr;
    assign im_wdata = r_im_wdata;
    assign cpu_rst  = r_cpu_rst;
    assign done     = r_done;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_im_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_im_loader
// Brief    : Self-checking bench for im_loader against an image-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_im_loader;

    localparam int c_aw    = 3;
    localparam int c_depth = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_req;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              im_we;
    logic [c_aw-1:0]   im_addr;
    logic [31:0]       im_wdata;
    logic              cpu_rst;
    logic              done;
    logic              err;

    im_loader #(.ADDR_W(c_aw)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .load_req (load_req),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .cpu_rst  (cpu_rst),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Bench-side instruction memory fed by the DUT write port
    logic [31:0] dut_mem [c_depth];
    logic [31:0] ref_mem [c_depth];
    logic [31:0] img [$];
    int          n_writes = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    int          n_total  = 0;
    bit          gaps     = 1'b0;

    always @(posedge clk) begin
        if (im_we) begin
            dut_mem[im_addr] <= im_wdata;
            n_writes = n_writes + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
            end
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        #1;
        check("rx_ready_in_load", {31'd0, rx_ready}, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8]);
    endtask

    task automatic send_header(input int n);
        logic [15:0] len;
        len = 16'(n);
        send_byte(len[15:8]);
        send_byte(len[7:0]);
    endtask

    task automatic make_image(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back($urandom);
    endtask

    // Model: the first 'completed' words of img land at addresses 0.., capped at depth
    task automatic ref_apply(input int completed);
        for (int i = 0; i < completed; i++) begin
            if (i < c_depth) ref_mem[i] = img[i];
        end
    endtask

    task automatic compare_mem();
        for (int i = 0; i < c_depth; i++)
            check($sformatf("mem[%0d]", i), dut_mem[i], ref_mem[i]);
    endtask

    task automatic pulse_load_req();
        @(negedge clk);
        load_req = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h00;
        #1;
        check("rx_ready_during_load_req", {31'd0, rx_ready}, 32'd0);
        @(negedge clk);
        load_req = 1'b0;
        rx_valid = 1'b0;
        #1;
        check("cpu_rst_after_load_req", {31'd0, cpu_rst}, 32'd1);
        check("done_after_load_req", {31'd0, done}, 32'd0);
        check("err_after_load_req", {31'd0, err}, 32'd0);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        @(negedge clk);
        rx_valid = 1'b0;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("done_reached", {31'd0, done}, 32'd1);
        check("cpu_rst_released", {31'd0, cpu_rst}, 32'd0);
    endtask

    task automatic run_image(input int n);
        int w0;
        w0 = n_writes;
        make_image(n);
        send_header(n);
        for (int i = 0; i < n; i++) send_word(img[i]);
        wait_done();
        ref_apply(n);
        check("err_flag", {31'd0, err}, {31'd0, n > c_depth});
        check("write_count", 32'(n_writes - w0), 32'((n > c_depth) ? c_depth : n));
        compare_mem();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int w0;
        rst      = 1'b1;
        load_req = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_im_we", {31'd0, im_we}, 32'd0);
        check("rst_im_addr", {29'd0, im_addr}, 32'd0);
        check("rst_im_wdata", im_wdata, 32'd0);
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        rst = 1'b0;

        // Two-word directed image with exact release timing
        img = '{32'h20080005, 32'hAC080000};
        send_header(2);
        send_word(img[0]);
        send_word(img[1]);
        @(negedge clk);
        rx_valid = 1'b0;
        check("t1_last_we", {31'd0, im_we}, 32'd1);
        check("t1_last_addr", {29'd0, im_addr}, 32'd1);
        check("t1_last_wdata", im_wdata, 32'hAC080000);
        check("t1_cpu_rst_still_high", {31'd0, cpu_rst}, 32'd1);
        check("t1_done_still_low", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("t1_cpu_rst_low", {31'd0, cpu_rst}, 32'd0);
        check("t1_done_high", {31'd0, done}, 32'd1);
        check("t1_we_low", {31'd0, im_we}, 32'd0);
        check("t1_rx_ready_done", {31'd0, rx_ready}, 32'd0);
        ref_apply(2);
        check("t1_write_count", 32'(n_writes), 32'd2);
        compare_mem();

        // Empty image
        pulse_load_req();
        w0 = n_writes;
        img.delete();
        send_header(0);
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        check("t2_done", {31'd0, done}, 32'd1);
        check("t2_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        check("t2_no_write", 32'(n_writes - w0), 32'd0);

        // Overflow: ten words into an eight-word memory
        pulse_load_req();
        run_image(10);

        // Abort mid-word, then a fresh one-word image; err from overflow is cleared
        pulse_load_req();
        w0 = n_writes;
        make_image(2);
        send_header(2);
        send_word(img[0]);
        send_byte(img[1][31:24]);
        send_byte(img[1][23:16]);
        ref_apply(1);
        pulse_load_req();
        img = '{32'h12345678};
        send_header(1);
        send_word(img[0]);
        wait_done();
        ref_apply(1);
        check("t5_addr0", dut_mem[0], 32'h12345678);
        check("t5_err", {31'd0, err}, 32'd0);
        check("t5_write_count", 32'(n_writes - w0), 32'd2);
        compare_mem();

        // Random images with random valid gaps
        gaps = 1'b1;
        for (int it = 0; it < 4; it++) begin
            pulse_load_req();
            run_image(int'($urandom_range(1, 9)));
        end
        gaps = 1'b0;

        // Asynchronous reset in the middle of a word
        pulse_load_req();
        make_image(3);
        send_header(3);
        send_word(img[0]);
        send_word(img[1]);
        send_byte(img[2][31:24]);
        send_byte(img[2][23:16]);
        ref_apply(2);
        @(negedge clk);
        rx_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("t6_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("t6_done", {31'd0, done}, 32'd0);
        check("t6_err", {31'd0, err}, 32'd0);
        check("t6_im_we", {31'd0, im_we}, 32'd0);
        check("t6_im_addr", {29'd0, im_addr}, 32'd0);
        check("t6_im_wdata", im_wdata, 32'd0);
        check("t6_rx_ready", {31'd0, rx_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        compare_mem();
        run_image(1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
